// File: rtl/cbus_ram_responder.sv
// CBUS RAM responder: 64-bit byte-strobed backing store serving FIXED/INCR bursts.
// Optional macro CBUS_RAM_WAIT_EN inserts WAIT_CYCLES idle cycles before the first beat.
package cbus_pkg;
   typedef enum logic { BURST_FIXED = 1'b0, BURST_INCR = 1'b1 } cbus_burst_e;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [3:0]  len;
      cbus_burst_e burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module cbus_ram_responder
   import cbus_pkg::*;
#(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  req,
   output cbus_resp_t resp,
   output logic       busy
);

   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] { ST_IDLE, ST_WAIT, ST_BURST } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [3:0]      len_q, len_d;
   logic [3:0]      beat_q, beat_d;
   cbus_burst_e     burst_q, burst_d;
   logic            wr_q, wr_d;
`ifdef CBUS_RAM_WAIT_EN
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
   logic [3:0]      wait_q, wait_d;
`endif

   logic [63:0]     mem [MEM_WORDS];
   logic [AW-1:0]   beat_idx;
   logic            beat_ok;
   logic            mem_we;
   logic            unused_req;

   // NOTE: every _d starts from its _q so no path through the case leaves a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      wr_d    = wr_q;
`ifdef CBUS_RAM_WAIT_EN
      wait_d  = wait_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req.valid) begin
               wr_d    = req.is_write;
               idx_d   = req.addr[3 +: AW];
               len_d   = req.len;
               burst_d = req.burst;
               beat_d  = 4'd0;
`ifdef CBUS_RAM_WAIT_EN
               wait_d  = 4'd0;
               state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BURST;
`else
               state_d = ST_BURST;
`endif
            end
         end
`ifdef CBUS_RAM_WAIT_EN
         ST_WAIT: begin
            if (!req.valid) begin
               state_d = ST_IDLE;
               wait_d  = 4'd0;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_BURST;
               wait_d  = 4'd0;
            end else begin
               wait_d  = wait_q + 4'd1;
            end
         end
`endif
         ST_BURST: begin
            // An abandoned request or the final beat both end the transaction.
            if (!req.valid || beat_q == len_q) begin
               state_d = ST_IDLE;
               beat_d  = 4'd0;
            end else begin
               beat_d  = beat_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= 4'd0;
         beat_q  <= 4'd0;
         burst_q <= BURST_FIXED;
         wr_q    <= 1'b0;
`ifdef CBUS_RAM_WAIT_EN
         wait_q  <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         wr_q    <= wr_d;
`ifdef CBUS_RAM_WAIT_EN
         wait_q  <= wait_d;
`endif
      end
   end

   assign beat_idx = (burst_q == BURST_INCR) ? idx_q + AW'(beat_q) : idx_q;
   assign beat_ok  = (state_q == ST_BURST) && req.valid;
   assign mem_we   = beat_ok && wr_q;
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      resp       = '0;
      resp.ready = beat_ok;
      resp.last  = beat_ok && (beat_q == len_q);
      if (beat_ok && !wr_q) begin
         resp.data = mem[beat_idx];
      end
   end

   // NOTE: the store has no reset so contents survive a reset, including partial bursts.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (req.strobe[b]) begin
               mem[beat_idx][8*b +: 8] <= req.data[8*b +: 8];
            end
         end
      end
   end

   // Size and out-of-range address bits are deliberately ignored.
`ifdef CBUS_RAM_WAIT_EN
   assign unused_req = ^{req.size, req.addr};
`else
   assign unused_req = ^{req.size, req.addr, 4'(WAIT_CYCLES)};
`endif

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed self-checking bench for cbus_ram_responder (16-word store, WAIT_CYCLES=3).
module tb_cbus_ram_responder;
   import cbus_pkg::*;

`ifdef CBUS_RAM_WAIT_EN
   localparam int EXP_WAIT = 3;
`else
   localparam int EXP_WAIT = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  req;
   cbus_resp_t resp;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] wbuf [16];
   logic [63:0] rbuf [16];

   cbus_ram_responder #(.MEM_WORDS(16), .WAIT_CYCLES(3)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .resp  (resp),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pass_wait(input string tag);
      for (int w = 0; w < EXP_WAIT; w++) begin
         check({tag, "_wait_ready"}, 64'(resp.ready), 64'd0);
         check({tag, "_wait_busy"}, 64'(busy), 64'd1);
         step();
      end
   endtask

   // Runs a complete transaction; writes use wbuf per beat, reads compare against rbuf.
   task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [3:0] len, input cbus_burst_e b, input logic [7:0] strb);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      req.valid    = 1'b1;
      req.is_write = wr;
      req.size     = 3'd3;
      req.addr     = addr;
      req.len      = len;
      req.burst    = b;
      req.strobe   = strb;
      req.data     = wbuf[0];
      step();
      req.addr  = 32'hFFFF_FFF8;
      req.len   = 4'd0;
      req.burst = cbus_burst_e'(~b);
      pass_wait(tag);
      for (int i = 0; i <= int'(len); i++) begin
         req.data = wbuf[i];
         #1;
         check({tag, "_ready"}, 64'(resp.ready), 64'd1);
         check({tag, "_last"}, 64'(resp.last), 64'(i == int'(len)));
         if (!wr) check({tag, "_data"}, resp.data, rbuf[i]);
         step();
      end
      req.valid = 1'b0;
      #1;
      check({tag, "_after_ready"}, 64'(resp.ready), 64'd0);
      check({tag, "_after_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      req   = '0;
      #2;
      check("rst_ready", 64'(resp.ready), 64'd0);
      check("rst_last", 64'(resp.last), 64'd0);
      check("rst_data", resp.data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      step();
      reset = 1'b0;

      // Single write then read, plus an aliased read of the same word.
      wbuf[0] = 64'h1122_3344_5566_7788;
      run_xfer("single_wr", 1'b1, 32'h40, 4'd0, BURST_FIXED, 8'hFF);
      rbuf[0] = 64'h1122_3344_5566_7788;
      run_xfer("single_rd", 1'b0, 32'h40, 4'd0, BURST_FIXED, 8'h00);
      run_xfer("alias_rd", 1'b0, 32'hC0, 4'd0, BURST_FIXED, 8'h00);

      // INCR burst of four at 0x100 (index 0 in a 16-word store).
      for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
      run_xfer("incr_wr", 1'b1, 32'h100, 4'd3, BURST_INCR, 8'hFF);
      for (int i = 0; i < 4; i++) rbuf[i] = 64'(i + 1);
      run_xfer("incr_rd", 1'b0, 32'h100, 4'd3, BURST_INCR, 8'h00);

      // Wrap-around from index 14: words 14,15,0,1.
      for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
      run_xfer("wrap_wr", 1'b1, 32'h70, 4'd3, BURST_INCR, 8'hFF);
      rbuf[0] = 64'hA2;
      run_xfer("wrap_fixed_rd", 1'b0, 32'h0, 4'd0, BURST_FIXED, 8'h00);
      for (int i = 0; i < 4; i++) rbuf[i] = 64'hA0 + 64'(i);
      run_xfer("wrap_incr_rd", 1'b0, 32'h70, 4'd3, BURST_INCR, 8'h00);
      rbuf[0] = 64'd3;
      run_xfer("wrap_untouched", 1'b0, 32'h10, 4'd0, BURST_FIXED, 8'h00);

      // FIXED write burst to one word keeps the final beat.
      wbuf[0] = 64'h51; wbuf[1] = 64'h52; wbuf[2] = 64'h53;
      run_xfer("fixed_wr", 1'b1, 32'h28, 4'd2, BURST_FIXED, 8'hFF);
      rbuf[0] = 64'h53;
      run_xfer("fixed_rd", 1'b0, 32'h28, 4'd0, BURST_FIXED, 8'h00);

      // Partial strobe touches only the low four bytes.
      wbuf[0] = '1;
      run_xfer("strb_full", 1'b1, 32'h30, 4'd0, BURST_FIXED, 8'hFF);
      wbuf[0] = 64'd0;
      run_xfer("strb_part", 1'b1, 32'h30, 4'd0, BURST_FIXED, 8'h0F);
      rbuf[0] = 64'hFFFF_FFFF_0000_0000;
      run_xfer("strb_rd", 1'b0, 32'h30, 4'd0, BURST_FIXED, 8'h00);

      // Reset during beat 2 of a len=7 write over words 8..15.
      for (int i = 0; i < 8; i++) wbuf[i] = 64'h100 + 64'(i);
      run_xfer("preset_wr", 1'b1, 32'h40, 4'd7, BURST_INCR, 8'hFF);
      req.valid = 1'b1; req.is_write = 1'b1; req.addr = 32'h40; req.len = 4'd7;
      req.burst = BURST_INCR; req.strobe = 8'hFF; req.data = 64'h200;
      step();
      pass_wait("rstmid");
      req.data = 64'h200;
      step();
      req.data = 64'h201;
      step();
      req.data = 64'h202;
      #1;
      check("rstmid_beat2_ready", 64'(resp.ready), 64'd1);
      reset = 1'b1;
      #1;
      check("rstmid_ready", 64'(resp.ready), 64'd0);
      check("rstmid_last", 64'(resp.last), 64'd0);
      check("rstmid_data", resp.data, 64'd0);
      check("rstmid_busy", 64'(busy), 64'd0);
      req.valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      rbuf[0] = 64'h200; rbuf[1] = 64'h201;
      for (int i = 2; i < 8; i++) rbuf[i] = 64'h100 + 64'(i);
      run_xfer("rstmid_rd", 1'b0, 32'h40, 4'd7, BURST_INCR, 8'h00);

      // Valid drops during beat 1: no write, ready/last low, back to IDLE.
      req.valid = 1'b1; req.is_write = 1'b1; req.addr = 32'h50; req.len = 4'd3;
      req.burst = BURST_INCR; req.strobe = 8'hFF; req.data = 64'h300;
      step();
      pass_wait("drop");
      check("drop_beat0_ready", 64'(resp.ready), 64'd1);
      step();
      req.valid = 1'b0;
      req.data  = 64'h301;
      #1;
      check("drop_ready", 64'(resp.ready), 64'd0);
      check("drop_last", 64'(resp.last), 64'd0);
      check("drop_busy_before", 64'(busy), 64'd1);
      step();
      check("drop_busy_after", 64'(busy), 64'd0);
      rbuf[0] = 64'h300; rbuf[1] = 64'h103; rbuf[2] = 64'h104; rbuf[3] = 64'h105;
      run_xfer("drop_rd", 1'b0, 32'h50, 4'd3, BURST_INCR, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
